// File: rtl/program_sequencer_if.sv
// Host/processor-facing signal bundle of the program sequencer: program load, start/length, DIN/Run/Done handshake and status.
interface program_sequencer_if #(
   parameter int AW = 4,
   parameter int DW = 16
);
   logic          WrEn;
   logic [AW-1:0] WrAddr;
   logic [DW-1:0] WrData;
   logic          Start;
   logic [AW:0]   Length;
   logic          Done;
   logic [DW-1:0] DIN;
   logic          Run;
   logic          Busy;
   logic          Finished;
   logic          Error;
   logic [AW-1:0] PC;

   modport master (
      output WrEn, WrAddr, WrData, Start, Length, Done,
      input  DIN, Run, Busy, Finished, Error, PC
   );

   modport slave (
      input  WrEn, WrAddr, WrData, Start, Length, Done,
      output DIN, Run, Busy, Finished, Error, PC
   );
endinterface

// File: rtl/program_sequencer.sv
// Issues words 0..Length-1 of a loadable program on DIN with Run high, one per Done; Run low for GAP+FETCH between words.
// Start->Run 2 cycles; Done->next Run 3 cycles; Start/WrEn ignored while Busy; Run aborts after TIMEOUT cycles without Done.
module program_sequencer #(
   parameter int AW      = 4,
   parameter int DW      = 16,
   parameter int TIMEOUT = 15
) (
   input logic              Clock,
   input logic              Resetn,
   program_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, GAP} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] mem [2**AW];
   logic [AW:0]   len;
   logic [AW-1:0] pc;
   logic [7:0]    cnt;
   logic [DW-1:0] din;
   logic          finished;
   logic          error;
   logic          run;
   logic          busy;
   logic          last_word;
   logic          timeout_hit;

   // Compare in AW+1 bits so a full-depth program completes even though pc wraps.
   assign last_word   = (({1'b0, pc} + (AW+1)'(1)) == len);
   assign timeout_hit = (cnt == 8'(TIMEOUT - 1));

   always_ff @(posedge Clock) begin
      if (!Resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      run       = 1'b0;
      busy      = 1'b1;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (bus.Start && (bus.Length != '0)) state_nxt = FETCH;
         end
         FETCH: state_nxt = ISSUE;
         ISSUE: begin
            run = 1'b1;
            if (bus.Done)       state_nxt = GAP;
            else if (timeout_hit) state_nxt = IDLE;
         end
         GAP: state_nxt = last_word ? IDLE : FETCH;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         din      <= '0;
         pc       <= '0;
         len      <= '0;
         cnt      <= '0;
         finished <= 1'b0;
         error    <= 1'b0;
      end else begin
         finished <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.Start) begin
                  len      <= bus.Length;
                  pc       <= '0;
                  error    <= 1'b0;
                  finished <= (bus.Length == '0);
               end
            end
            FETCH: begin
               din <= mem[pc];
               cnt <= '0;
            end
            ISSUE: begin
               cnt <= cnt + 8'd1;
               if (!bus.Done && timeout_hit) error <= 1'b1;
            end
            GAP: begin
               pc <= pc + AW'(1);
               if (last_word) finished <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Program memory survives reset; writes land the same edge Start is taken, so FETCH sees them.
   always_ff @(posedge Clock) begin
      if (Resetn && (state == IDLE) && bus.WrEn) mem[bus.WrAddr] <= bus.WrData;
   end

   assign bus.DIN      = din;
   assign bus.Run      = run;
   assign bus.Busy     = busy;
   assign bus.Finished = finished;
   assign bus.Error    = error;
   assign bus.PC       = pc;
endmodule
